imm_packer: RTL and testbench

IMM_PACKER -- requirements
Module: imm_packer

---
 rtl/imm_packer.sv | 113 +++++++++++
 tb/tb_imm_packer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - packs an immediate into an instruction word and queues it in an in-order FIFO
module imm_packer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_U = 3'd1,
    IMM_J = 3'd2,
    IMM_S = 3'd3
  } imm_type_e;

  logic [31:0]   mem_instr_q [DEPTH];
  logic          mem_err_q   [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic [31:0] pk_instr;
  logic        pk_err;
  logic        push, pop;

  // Error means sign-extending the truncated field would not reproduce imm.
  always_comb begin
    pk_instr = base;
    pk_err   = 1'b0;
    case (imm_src)
      IMM_I: begin
        pk_instr = {imm[11:0], base[19:0]};
        pk_err   = !((&imm[31:11]) || !(|imm[31:11]));
      end
      IMM_U: begin
        pk_instr = {imm[31:12], base[11:0]};
        pk_err   = |imm[11:0];
      end
      IMM_J: begin
        pk_instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        pk_err   = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
      end
      IMM_S: begin
        pk_instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        pk_err   = !((&imm[31:11]) || !(|imm[31:11]));
      end
      default: begin
        pk_instr = base;
        pk_err   = 1'b1;
      end
    endcase
  end

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign in_ready  = (count_q < CW'(DEPTH)) || pop;
  assign push      = in_valid && in_ready;
  assign out_instr = out_valid ? mem_instr_q[rptr_q] : 32'h0;
  assign out_err   = out_valid ? mem_err_q[rptr_q] : 1'b0;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    wptr_d    = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + PW'(1) : rptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && pk_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wptr_q] <= pk_instr;
      mem_err_q[wptr_q]   <= pk_err;
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// tb/tb_imm_packer.sv - self-checking bench for imm_packer
module tb_imm_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  imm_src = 3'd0;
  logic [31:0] imm = 32'h0;
  logic [31:0] base = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] base;
  } req_t;

  imm_packer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_src(imm_src), .imm(imm), .base(base), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] sext(input logic [31:0] x, input int bits);
    logic [31:0] m, s;
    m = (32'h1 << bits) - 32'h1;
    s = 32'h1 << (bits - 1);
    return ((x & m) ^ s) - s;
  endfunction

  // Value an ideal packer can represent for this type.
  function automatic logic [31:0] canon(input logic [2:0] src, input logic [31:0] v);
    case (src)
      3'd0, 3'd3: return sext(v, 12);
      3'd1:       return v & ~32'hFFF;
      3'd2:       return sext(v, 21) & ~32'h1;
      default:    return v;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] src, input logic [31:0] w);
    case (src)
      3'd0:    return sext({20'h0, w[31:20]}, 12);
      3'd1:    return {w[31:12], 12'h0};
      3'd2:    return sext({11'h0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
      3'd3:    return sext({20'h0, w[31:25], w[11:7]}, 12);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] keep_mask(input logic [2:0] src);
    case (src)
      3'd0:    return 32'h000F_FFFF;
      3'd1:    return 32'h0000_0FFF;
      3'd2:    return 32'h0000_0FFF;
      3'd3:    return 32'h01FF_F07F;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic model_err(input req_t r);
    return (r.src > 3'd3) || (canon(r.src, r.imm) != r.imm);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr: got %h want 00000000", out_instr); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_err_cnt: got %h want 0000", err_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick(); tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [2:0]  t_src [5]  = '{3'd0, 3'd2, 3'd2, 3'd3, 3'd1};
    logic [31:0] t_imm [5]  = '{32'hFFFFF800, 32'h00000801, 32'h00000800, 32'hFFFFFFFC, 32'h12345000};
    logic [31:0] t_base [5] = '{32'h00000513, 32'h000000EF, 32'h000000EF, 32'h00112023, 32'h00000537};
    logic [31:0] t_out [5]  = '{32'h80000513, 32'h001000EF, 32'h001000EF, 32'hFE112E23, 32'h12345537};
    logic        t_err [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] t_cnt [5]  = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imm_src = t_src[i]; imm = t_imm[i]; base = t_base[i]; in_valid = 1'b1;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir%0d_no_bypass: got out_valid=%b want 0", i, out_valid); end
      tick();
      in_valid = 1'b0; imm = 32'h0; base = 32'h0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir%0d_latency: got out_valid=%b want 1", i, out_valid); end
      n_cmp++; if (out_instr !== t_out[i]) begin n_bad++; $display("FAIL dir%0d_instr: got %h want %h", i, out_instr, t_out[i]); end
      n_cmp++; if (out_err !== t_err[i]) begin n_bad++; $display("FAIL dir%0d_err: got %b want %b", i, out_err, t_err[i]); end
      n_cmp++; if (err_cnt !== t_cnt[i]) begin n_bad++; $display("FAIL dir%0d_err_cnt: got %0d want %0d", i, err_cnt, t_cnt[i]); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir_drained: got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w;
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      imm_src = 3'd0; imm = 32'(i + 1); base = 32'h00000013; in_valid = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== (i < DEPTH)) begin n_bad++; $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, (i < DEPTH)); end
      if (i < DEPTH) tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_on_pop: got %b want 1", in_ready); end
    n_cmp++; if (out_instr !== 32'h00100013) begin n_bad++; $display("FAIL bp_word0: got %h want 00100013", out_instr); end
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      exp_w = (32'(k + 1) << 20) | 32'h13;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid_%0d: got %b want 1", k, out_valid); end
      n_cmp++; if (out_instr !== exp_w) begin n_bad++; $display("FAIL bp_word%0d: got %h want %h", k, out_instr, exp_w); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    imm_src = 3'd5; base = 32'hDEADBEEF; imm = 32'h0; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pre_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_instr !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ar_pre_instr: got %h want deadbeef", out_instr); end
    n_cmp++; if (err_cnt !== 16'd3) begin n_bad++; $display("FAIL ar_pre_err_cnt: got %0d want 3", err_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    n_cmp++; if (err_cnt !== 16'h0) begin n_bad++; $display("FAIL ar_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL ar_instr: got %h want 00000000", out_instr); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    tick();
    #3 rst_n = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_no_stale: got %b want 0", out_valid); end
    imm_src = 3'd0; imm = 32'h5; base = 32'h00000093; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_instr !== 32'h00500093) begin n_bad++; $display("FAIL ar_first_word: got %h want 00500093", out_instr); end
    n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL ar_first_err: got %b want 0", out_err); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ar_post_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    req_t q[$];
    req_t r, e;
    int   exp_errs;
    logic exp_rdy;
    logic [31:0] c;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    exp_errs = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      in_valid  = (cyc < 850) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (cyc < 850) ? ($urandom_range(0, 2) != 0) : 1'b1;
      r.src  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      r.imm  = $urandom;
      if ($urandom_range(0, 1) == 1) r.imm = canon(r.src, r.imm);
      r.base = $urandom;
      imm_src = r.src; imm = r.imm; base = r.base;
      #1;
      exp_rdy = (q.size() < DEPTH) || ((q.size() > 0) && out_ready);
      n_cmp++; if (out_valid !== (q.size() > 0)) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid, (q.size() > 0)); end
      n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", cyc, in_ready, exp_rdy); end
      if (out_valid && out_ready && (q.size() > 0)) begin
        e = q.pop_front();
        if (e.src <= 3'd3) begin
          c = canon(e.src, e.imm);
          n_cmp++; if (extend(e.src, out_instr) !== c) begin n_bad++; $display("FAIL rnd_roundtrip@%0d: src=%0d got %h want %h", cyc, e.src, extend(e.src, out_instr), c); end
          n_cmp++; if ((out_instr & keep_mask(e.src)) !== (e.base & keep_mask(e.src))) begin n_bad++; $display("FAIL rnd_base@%0d: got %h want %h", cyc, out_instr & keep_mask(e.src), e.base & keep_mask(e.src)); end
        end else begin
          n_cmp++; if (out_instr !== e.base) begin n_bad++; $display("FAIL rnd_unsup@%0d: got %h want %h", cyc, out_instr, e.base); end
        end
        n_cmp++; if (out_err !== model_err(e)) begin n_bad++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, out_err, model_err(e)); end
      end
      if (in_valid && in_ready) begin
        q.push_back(r);
        if (model_err(r)) exp_errs++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (q.size() != 0) begin n_bad++; $display("FAIL rnd_drain: got %0d left want 0", q.size()); end
    n_cmp++; if (err_cnt !== 16'(exp_errs)) begin n_bad++; $display("FAIL rnd_err_cnt: got %0d want %0d", err_cnt, exp_errs); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
